// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: GF(16)/GF((2^4)^2) tower-field constants and arithmetic helpers
package aes_gf_pkg;
  localparam logic [3:0] LAMBDA = 4'hE;
  localparam logic [4:0] GF16_POLY = 5'h13;
  localparam logic [63:0] GF16_INV_TAB = 64'h834A5C2F67BDE910;
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = p ^ (b[i] ? t : 4'h0);
      t = {t[2:0], 1'b0} ^ (t[3] ? GF16_POLY[3:0] : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return gf16_mul(a, a);
  endfunction
  function automatic logic [3:0] gf16_mul_lambda(input logic [3:0] a);
    return gf16_mul(a, LAMBDA);
  endfunction
  function automatic logic [3:0] gf16_inv_lut(input logic [3:0] a);
    return GF16_INV_TAB[{a, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/gf256_tower_inv_pipe_gf16_inv.sv
// gf16_inv: combinational GF(16) inverter, 0 maps to 0
module gf16_inv
  import aes_gf_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = gf16_inv_lut(a);
endmodule

// File: rtl/gf256_tower_inv_pipe.sv
// gf256_tower_inv_pipe: pipelined GF((2^4)^2) inverter with valid/ready back-pressure
module gf256_tower_inv_pipe #(
  parameter int STAGES = 3,
  parameter logic [3:0] LAMBDA = 4'hE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);
  import aes_gf_pkg::*;
  logic [STAGES-1:0] v, ld, tk;
  logic [3:0] ih, il, d_in, d_src, di, ph, px, pdi;
  logic [7:0] od;
  assign ih = in_data[7:4];
  assign il = in_data[3:0];
  assign d_in = gf16_mul_lambda(gf16_sq(ih)) ^ gf16_mul(ih, il) ^ gf16_sq(il);
  for (genvar g = 0; g < STAGES; g++) begin : g_ld
    assign ld[g] = out_ready | ~&v[STAGES-1:g];
  end
  assign tk = ld & {v[STAGES-2:0], in_valid} & {STAGES{!clr}};
  assign in_ready = ld[0] & !clr;
  assign out_valid = v[STAGES-1];
  assign out_data = od;
  gf16_inv u_inv (.a(d_src), .y(di));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= clr ? '0 : (v & ~ld) | tk;
  if ((STAGES != 2 && STAGES != 3) || LAMBDA != aes_gf_pkg::LAMBDA) begin : g_bad
    $error("gf256_tower_inv_pipe: STAGES must be 2 or 3 and LAMBDA must match aes_gf_pkg");
  end else if (STAGES == 3) begin : g_s3
    logic [3:0] s1h, s1x, s1d;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1h, s1x, s1d} <= '0;
      else if (tk[0]) {s1h, s1x, s1d} <= {ih, ih ^ il, d_in};
    assign d_src = s1d;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {ph, px, pdi} <= '0;
      else if (tk[1]) {ph, px, pdi} <= {s1h, s1x, di};
  end else begin : g_s2
    assign d_src = d_in;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {ph, px, pdi} <= '0;
      else if (tk[0]) {ph, px, pdi} <= {ih, ih ^ il, di};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) od <= '0;
    else if (tk[STAGES-1]) od <= {gf16_mul(ph, pdi), gf16_mul(px, pdi)};
endmodule

// File: tb/tb_gf256_tower_inv_pipe.sv
// tb_gf256_tower_inv_pipe: scoreboard bench for the tower-field inverter pipeline
module tb_gf256_tower_inv_pipe;
  localparam int STAGES = 3;
  typedef struct {
    logic [7:0] d;
    int t;
    bit lat;
  } exp_t;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [7:0] in_data = 8'h00, out_data, hold;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, stalls = 0, gaps = 0;
  bit rnd = 0, win = 0;
  gf256_tower_inv_pipe #(.STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) if (win && !out_valid) gaps++;
  function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction
  function automatic logic [7:0] m256(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = m16(a[7:4], b[7:4]);
    return {hh ^ m16(a[7:4], b[3:0]) ^ m16(a[3:0], b[7:4]), m16(hh, 4'hE) ^ m16(a[3:0], b[3:0])};
  endfunction
  function automatic logic [7:0] inv256(input logic [7:0] a);
    for (int b = 1; b < 256; b++) if (m256(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic push(input logic [7:0] b, input logic [7:0] e, input bit ex, input bit lat);
    int w = 0;
    in_valid = 1;
    in_data = b;
    @(negedge clk);
    while (!in_ready && w < 1000) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %h not accepted, required in_ready=1", b);
    end else begin
      stalls += w;
      if (ex) exp_q.push_back('{d: e, t: cyc, lat: lat});
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_data = 8'($urandom);
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got %h, required no output", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.d) begin
          n_bad++;
          $display("FAIL out_data: got %h, required %h", out_data, e.d);
        end
        if (e.lat) begin
          n_cmp++;
          if (cyc - e.t != STAGES) begin
            n_bad++;
            $display("FAIL latency: got %0d, required %0d", cyc - e.t, STAGES);
          end
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    push(8'h00, 8'h00, 1, 1);
    push(8'h01, 8'h01, 1, 1);
    push(8'h10, 8'h33, 1, 1);
    push(8'h33, 8'h10, 1, 1);
    repeat (6) @(posedge clk);
    #1;
    stalls = 0;
    for (int i = 0; i < 256; i++) push(8'(i), inv256(8'(i)), 1, 1);
    chk("stream_stalls", 32'(stalls), 0);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 0;
    for (int i = 0; i < STAGES; i++) push(8'h20 + 8'(i), inv256(8'h20 + 8'(i)), 1, 0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_head", 32'(out_data), 32'(inv256(8'h20)));
    hold = out_data;
    repeat (5) @(negedge clk);
    chk("stall_stable", 32'(out_data), 32'(hold));
    chk("stall_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    stalls = 0;
    gaps = 0;
    win = 1;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), inv256(8'h40 + 8'(i)), 1, 0);
    win = 0;
    chk("popush_stalls", 32'(stalls), 0);
    chk("popush_gaps", 32'(gaps), 0);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 0;
    push(8'h55, 8'h00, 0, 0);
    push(8'h66, 8'h00, 0, 0);
    in_valid = 1;
    in_data = 8'h77;
    clr = 1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clr = 0;
    in_valid = 0;
    @(negedge clk);
    chk("clr_out_valid", 32'(out_valid), 0);
    chk("clr_in_ready_after", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    push(8'h88, 8'h00, 0, 0);
    push(8'h99, 8'h00, 0, 0);
    in_valid = 1;
    in_data = 8'hAA;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    push(8'h53, inv256(8'h53), 1, 1);
    repeat (5) @(posedge clk);
    #1;
    rnd = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [7:0] b;
        b = 8'($urandom);
        push(b, inv256(b), 1, 0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    rnd = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
